// File: rtl/pulse_hs_rx_pkg.sv
// Shared definitions for the 4-phase handshake responder.
package pulse_hs_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_ACK   = 2'd2
  } state_e;

  localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage

// File: rtl/pulse_hs_rx_bit_sync_chain.sv
// Single-bit multi-flop synchronizer, asynchronously cleared to 0.
module bit_sync_chain
  import pulse_hs_rx_pkg::*;
#(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  if (STAGES < SYNC_STAGES_MIN) begin : g_bad_stages
    $error("bit_sync_chain: STAGES must be at least 2");
  end

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  // Shift the asynchronous level through the synchronizer flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_hs_rx.sv
// Responder side of a 4-phase req/ack CDC handshake: captures the word sent
// with req, offers it once on valid/ready, then acknowledges back.
module pulse_hs_rx
  import pulse_hs_rx_pkg::*;
#(
  parameter int unsigned DW          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_async,
  input  logic [DW-1:0]    data_async,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DW-1:0]    out_data,
  output logic             ack,
  output logic [CNT_W-1:0] xfer_cnt,
  output logic             proto_err
);

  logic             req_s;
  state_e           state_q,     state_d;
  logic             valid_q,     valid_d;
  logic [DW-1:0]    data_q,      data_d;
  logic             ack_q,       ack_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             perr_q,      perr_d;
  logic             err_seen_q,  err_seen_d;

  bit_sync_chain #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (req_async),
    .q_o   (req_s)
  );

  // Next-state and registered-output decode of the handshake FSM.
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    data_d     = data_q;
    ack_d      = ack_q;
    cnt_d      = cnt_q;
    perr_d     = 1'b0;
    err_seen_d = err_seen_q;
    case (state_q)
      ST_IDLE: begin
        ack_d      = 1'b0;
        err_seen_d = 1'b0;
        // data_async is quasi-static here: the sender holds it until it sees ack.
        if (req_s) begin
          data_d  = data_async;
          valid_d = 1'b1;
          state_d = ST_VALID;
        end else begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_VALID: begin
        if (!req_s && !err_seen_q) begin
          perr_d     = 1'b1;
          err_seen_d = 1'b1;
        end else begin
          perr_d     = 1'b0;
        end
        if (valid_q && out_ready) begin
          valid_d = 1'b0;
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end else begin
          state_d = ST_VALID;
        end
      end
      ST_ACK: begin
        valid_d = 1'b0;
        if (!req_s) begin
          ack_d   = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = ST_IDLE;
        end else begin
          ack_d   = 1'b1;
          state_d = ST_ACK;
        end
      end
      default: begin
        valid_d = 1'b0;
        ack_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      valid_q    <= 1'b0;
      data_q     <= {DW{1'b0}};
      ack_q      <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
      perr_q     <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
      cnt_q      <= cnt_d;
      perr_q     <= perr_d;
      err_seen_q <= err_seen_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign ack       = ack_q;
  assign xfer_cnt  = cnt_q;
  assign proto_err = perr_q;

endmodule

// File: tb/tb_pulse_hs_rx.sv
// Directed and randomized checks of pulse_hs_rx against a word-queue/counter model.
module tb_pulse_hs_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_async = 1'b0;
  logic [7:0] data_async = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid, out_valid2;
  logic [7:0] out_data, out_data2;
  logic       ack, ack2;
  logic [7:0] xfer_cnt;
  logic [1:0] xfer_cnt2;
  logic       proto_err, proto_err2;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  int perr_seen = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  pulse_hs_rx #(.DW(8), .SYNC_STAGES(2), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_async(req_async), .data_async(data_async),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .ack(ack), .xfer_cnt(xfer_cnt), .proto_err(proto_err)
  );

  pulse_hs_rx #(.DW(8), .SYNC_STAGES(2), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_async(req_async), .data_async(data_async),
    .out_ready(out_ready), .out_valid(out_valid2), .out_data(out_data2),
    .ack(ack2), .xfer_cnt(xfer_cnt2), .proto_err(proto_err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, "_cnt8"}, {24'd0, xfer_cnt}, exp_cnt % 256);
    chk({tag, "_cnt2"}, {30'd0, xfer_cnt2}, exp_cnt % 4);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_async = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_cnt = 0;
    exp_q.delete();
    tick();
  endtask

  // One full 4-phase transfer as the sender; optional random backpressure.
  task automatic send(input logic [7:0] w, input bit rnd_ready);
    int k;
    int hold;
    data_async = w;
    req_async  = 1'b1;
    exp_q.push_back(w);
    k = 0;
    while (ack !== 1'b1 && k < 200) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      k++;
    end
    chk("ack_rise", {31'd0, ack}, 32'd1);
    hold = $urandom_range(0, 4);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("no_retrigger", {31'd0, out_valid | out_valid2}, 32'd0);
    end
    req_async  = 1'b0;
    data_async = 8'($urandom_range(0, 255));
    k = 0;
    while (ack !== 1'b0 && k < 200) begin
      tick();
      k++;
    end
    chk("ack_fall", {31'd0, ack}, 32'd0);
    exp_cnt++;
    chk_cnt("send");
  endtask

  // Every accepted word must be the oldest one the sender has offered.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (proto_err === 1'b1) perr_seen++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(exp_q.size()), 32'd1);
        end else begin
          chk("word", {24'd0, out_data}, {24'd0, exp_q[0]});
          chk("word_dut2", {24'd0, out_data2}, {24'd0, exp_q[0]});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int k;
    int cnt;

    // 1: reset holds everything low even with req asserted
    req_async = 1'b1;
    data_async = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_ack", {31'd0, ack}, 32'd0);
      chk("rst_data", {24'd0, out_data}, 32'd0);
      chk("rst_cnt", {24'd0, xfer_cnt}, 32'd0);
      chk("rst_perr", {31'd0, proto_err}, 32'd0);
    end
    req_async = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();

    // 2: latency of valid and ack
    data_async = 8'hA5;
    req_async  = 1'b1;
    out_ready  = 1'b1;
    exp_q.push_back(8'hA5);
    tick(); chk("t2_e1_valid", {31'd0, out_valid}, 32'd0);
    tick(); chk("t2_e2_valid", {31'd0, out_valid}, 32'd0);
    tick(); chk("t2_e3_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_e3_data", {24'd0, out_data}, 32'hA5);
    chk("t2_e3_ack", {31'd0, ack}, 32'd0);
    tick(); chk("t2_e4_valid", {31'd0, out_valid}, 32'd0);
    chk("t2_e4_ack", {31'd0, ack}, 32'd1);
    req_async = 1'b0;
    tick(); chk("t2_f1_ack", {31'd0, ack}, 32'd1);
    tick(); chk("t2_f2_ack", {31'd0, ack}, 32'd1);
    tick(); chk("t2_f3_ack", {31'd0, ack}, 32'd0);
    exp_cnt++;
    chk_cnt("t2");

    // 3: backpressure holds the word and withholds ack
    data_async = 8'h3C;
    req_async  = 1'b1;
    out_ready  = 1'b0;
    exp_q.push_back(8'h3C);
    tick(); tick(); tick();
    for (int i = 0; i < 10; i++) begin
      chk("t3_valid", {31'd0, out_valid}, 32'd1);
      chk("t3_data", {24'd0, out_data}, 32'h3C);
      chk("t3_ack", {31'd0, ack}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t3_acc_valid", {31'd0, out_valid}, 32'd0);
    chk("t3_acc_ack", {31'd0, ack}, 32'd1);
    req_async = 1'b0;
    k = 0;
    while (ack !== 1'b0 && k < 50) begin tick(); k++; end
    chk("t3_ack_fall", {31'd0, ack}, 32'd0);
    exp_cnt++;
    chk_cnt("t3");

    // 4: five back-to-back words; the 2-bit counter wraps to 1
    do_reset();
    for (int i = 1; i <= 5; i++) send(8'(i), 1'b0);
    chk("t4_drained", 32'(exp_q.size()), 32'd0);
    chk("t4_cnt2", {30'd0, xfer_cnt2}, 32'd1);

    // 5: req withdrawn while the word is still pending
    data_async = 8'h77;
    req_async  = 1'b1;
    out_ready  = 1'b0;
    exp_q.push_back(8'h77);
    tick(); tick(); tick();
    chk("t5_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_data", {24'd0, out_data}, 32'h77);
    req_async = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (proto_err === 1'b1) cnt++;
      chk("t5_no_ack", {31'd0, ack}, 32'd0);
    end
    chk("t5_perr_pulses", 32'(cnt), 32'd1);
    chk("t5_still_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    chk("t5_ack_hi", {31'd0, ack}, 32'd1);
    chk("t5_valid_lo", {31'd0, out_valid}, 32'd0);
    tick();
    chk("t5_ack_lo", {31'd0, ack}, 32'd0);
    exp_cnt++;
    chk_cnt("t5");
    chk("t5_drained", 32'(exp_q.size()), 32'd0);

    // 6: asynchronous reset while in ACK
    data_async = 8'h5A;
    req_async  = 1'b1;
    out_ready  = 1'b1;
    exp_q.push_back(8'h5A);
    k = 0;
    while (ack !== 1'b1 && k < 50) begin tick(); k++; end
    chk("t6_in_ack", {31'd0, ack}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_ack", {31'd0, ack}, 32'd0);
    chk("t6_async_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_async_cnt", {24'd0, xfer_cnt}, 32'd0);
    req_async = 1'b0;
    exp_cnt = 0;
    tick(); tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid === 1'b1 || ack === 1'b1) cnt++;
    end
    chk("t6_no_spurious", 32'(cnt), 32'd0);

    // Randomized transfers with random downstream backpressure
    for (int i = 0; i < 25; i++) send(8'($urandom_range(0, 255)), 1'b1);
    tick(); tick();
    chk("rand_drained", 32'(exp_q.size()), 32'd0);
    chk("perr_total", 32'(perr_seen), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
